vi_stream_checker: RTL and testbench
====================================

# vi_stream_checker

Passive monitor on the video-input pixel stream, placed directly downstream of the test-pattern generator in the `vo_clk` domain. It sits in parallel with the real consumer.
- Checks framing per frame: vsync, req, eol and eof ordering; line length; lines per frame.
- Reports measured geometry, sticky error flags, a frame counter and an optional per-frame CRC for bring-up.
- Never back-pressures the stream.

## Interface
Parameters:
- `EXP_WIDTH`, 1280: expected active pixels per line (1..4095).
- `EXP_HEIGHT`, 1024: expected active lines per frame (1..2047).

Ports:
- `vo_clk`  in  1  pixel clock; all logic is on its rising edge.
- `vo_reset`  in  1  synchronous, active-high reset.
- `in_vsync`  in  1  one-cycle start-of-frame pulse.
- `in_req`  in  1  pixel valid.
- `in_eol`  in  1  last pixel of line; qualified by `in_req`.
- `in_eof`  in  1  last pixel of frame; qualified by `in_req` and `in_eol`.
- `in_pixel`  in  24  RGB pixel data.
- `clr_err`  in  1  clears all sticky error flags.
- `frame_done`  out  1  one-cycle pulse when a frame closes.
- `frame_cnt`  out  16  count of completed frames; wraps.
- `line_len`  out  12  measured length of the most recent line.
- `frame_lines`  out  11  line count of the most recently closed frame.
- `err_line_len`  out  1  sticky: a line length differed from `EXP_WIDTH`.
- `err_frame_lines`  out  1  sticky: a frame line count differed from `EXP_HEIGHT`.
- `err_sync`  out  1  sticky: protocol violation.
- `frame_crc`  out  32  CRC of the last closed frame.

## Operation
- **State machine:**
  - IDLE (reset) → ARMED on `in_vsync`. All other inputs are ignored in IDLE.
  - ARMED → ACTIVE on the first `in_req`.
  - ACTIVE → DONE on `in_req & in_eol & in_eof`.
  - DONE → ARMED on `in_vsync`.
- **Counters:**
  - `pix_cntr` (12b) counts `in_req` within a line and saturates at 4095.
  - `line_cntr` (11b) counts eol events within a frame and saturates at 2047.
  - Both clear on `in_vsync`. `pix_cntr` also clears after each eol.
- **Line close** (`in_req & in_eol`, in ARMED or ACTIVE):
  - `line_len <= pix_cntr+1`, saturating.
  - If that value ≠ `EXP_WIDTH`, set `err_line_len`.
- **Frame close** (eof):
  - `frame_lines <= line_cntr+1`, saturating.
  - If that value ≠ `EXP_HEIGHT`, set `err_frame_lines`.
  - `frame_cnt` increments and `frame_done` pulses.
- **`err_sync` is set on any of:**
  - `in_eol` without `in_req`;
  - `in_eof` without `in_req & in_eol`;
  - `in_req` in DONE;
  - `in_vsync` in ACTIVE. This abandons the frame: no `frame_done`, counters clear, next state ARMED.
  - `in_vsync` in ARMED is legal and simply re-arms.
- **Error clearing:** `clr_err` clears all three error flags. If a new error is detected in the same cycle, the error wins (flag stays set).
- **Simultaneous events:** `in_vsync` together with `in_req` is treated as vsync first, then the pixel is counted as the first pixel of the new frame.

## Timing
- All outputs are registered and update the cycle after the causing input.
- `frame_done` is high exactly one cycle, the cycle after the eof input.
- `line_len`, `frame_lines`, `frame_cnt` and `frame_crc` are all valid in that same cycle and hold until the next update.
- Reset values: `frame_done`=0, `frame_cnt`=0, `line_len`=0, `frame_lines`=0, all error flags=0, `frame_crc`=0, state IDLE.
- Reset mid-frame discards everything. The checker re-syncs on the next `in_vsync`.
- No ready/stall path exists; every cycle is accepted.

## Configuration
- **`VI_CHECK_CRC_EN` defined:**
  - Running CRC-32 (reflected poly 0xEDB88320), initialised to 0xFFFFFFFF on `in_vsync`.
  - Each accepted pixel feeds bytes in order `[7:0]`, `[15:8]`, `[23:16]`, i.e. 24 bits per cycle.
  - At frame close, `frame_crc <= crc ^ 0xFFFFFFFF`.
- **Undefined:** no CRC logic; `frame_crc` is tied to 0.

## Test plan
Benches use `EXP_WIDTH`=8 and `EXP_HEIGHT`=4.
- **Clean frames:** vsync, then 4 lines of 8 req with eol/eof correct, ×3 → three `frame_done` pulses; `frame_cnt`=3, `line_len`=8, `frame_lines`=4, all errors 0.
- **Short line:** line 2 has 7 pixels → `err_line_len`=1 the cycle after that eol, `line_len`=7; `err_line_len` stays 1 after the following good frame.
- **Early eof:** eof on line 3 → `frame_lines`=3, `err_frame_lines`=1, `frame_done` pulses.
- **Protocol violations:**
  - vsync mid-line → `err_sync`=1, no `frame_done`; the next good frame completes with `frame_lines`=4.
  - eol without req → `err_sync`=1.
- **clr_err:** `clr_err` alone clears all flags. `clr_err` in the same cycle as a req in DONE → `err_sync` remains 1.
- **CRC (macro on):** frame of pixel values 0..31 → `frame_crc` equals the software CRC-32 of the 96-byte stream. With the macro off, `frame_crc`=0.

Source files
------------

// File: rtl/vi_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : vi_stream_checker
// Purpose  : Passive framing monitor for the video-input pixel stream in the
//            vo_clk domain. Checks vsync/req/eol/eof ordering, line length and
//            lines per frame, reports measured geometry, sticky error flags, a
//            frame counter and (optionally) a per-frame CRC-32. The stream is
//            only observed; it is never stalled.
//
// Ports    : vo_clk          pixel clock, rising edge
//            vo_reset        synchronous active-high reset
//            in_vsync        one-cycle start-of-frame pulse
//            in_req          pixel valid
//            in_eol          last pixel of line (qualified by in_req)
//            in_eof          last pixel of frame (qualified by in_req & in_eol)
//            in_pixel[23:0]  RGB pixel data (only used by the CRC)
//            clr_err         clears the sticky error flags
//            frame_done      one-cycle pulse after the eof pixel
//            frame_cnt[15:0] completed frames, wrapping
//            line_len[11:0]  length of the most recent line (saturating)
//            frame_lines[10:0] line count of the last closed frame
//            err_line_len    sticky: line length != EXP_WIDTH
//            err_frame_lines sticky: frame line count != EXP_HEIGHT
//            err_sync        sticky: protocol violation
//            frame_crc[31:0] CRC-32 of the last closed frame (0 without CRC)
//
// Options  : define VI_CHECK_CRC_EN to build the per-frame CRC-32
//            (reflected poly 0xEDB88320, bytes [7:0],[15:8],[23:16]).
//
// Revision : 1.0 - initial release
// ============================================================================
module vi_stream_checker #(
    parameter int EXP_WIDTH  = 1280,
    parameter int EXP_HEIGHT = 1024
) (
    input  logic        vo_clk,
    input  logic        vo_reset,
    input  logic        in_vsync,
    input  logic        in_req,
    input  logic        in_eol,
    input  logic        in_eof,
    input  logic [23:0] in_pixel,
    input  logic        clr_err,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        err_line_len,
    output logic        err_frame_lines,
    output logic        err_sync,
    output logic [31:0] frame_crc
);

    localparam logic [1:0]  c_st_idle    = 2'd0;
    localparam logic [1:0]  c_st_armed   = 2'd1;
    localparam logic [1:0]  c_st_active  = 2'd2;
    localparam logic [1:0]  c_st_done    = 2'd3;

    localparam logic [11:0] c_pix_max    = 12'd4095;
    localparam logic [10:0] c_line_max   = 11'd2047;
    localparam logic [11:0] c_exp_width  = 12'(EXP_WIDTH);
    localparam logic [10:0] c_exp_height = 11'(EXP_HEIGHT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  w_eff_state;
    logic        w_pix_ok;
    logic        w_line_close;
    logic        w_frame_close;
    logic        w_sync_err;

    logic [11:0] r_pix_cntr;
    logic [11:0] w_pix_base;
    logic [11:0] w_pix_inc;
    logic [10:0] r_line_cntr;
    logic [10:0] w_line_base;
    logic [10:0] w_line_inc;
    logic        w_new_line_err;
    logic        w_new_frame_err;

    logic        r_frame_done;
    logic [15:0] r_frame_cnt;
    logic [11:0] r_line_len;
    logic [10:0] r_frame_lines;
    logic        r_err_line_len;
    logic        r_err_frame_lines;
    logic        r_err_sync;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and per-cycle events.
    // vsync is applied first: it moves the effective state to ARMED, and the
    // rest of the cycle (a coincident pixel) is then evaluated from there.
    // ------------------------------------------------------------------------
    always_comb begin
        w_eff_state   = r_state;
        w_state_nxt   = r_state;
        w_sync_err    = 1'b0;
        w_pix_ok      = 1'b0;
        w_line_close  = 1'b0;
        w_frame_close = 1'b0;

        if (in_vsync) begin
            // vsync while a frame is in flight abandons that frame
            if (r_state == c_st_active) begin
                w_sync_err = 1'b1;
            end
            w_eff_state = c_st_armed;
        end

        // Qualifier violations; nothing is checked until the first vsync
        if (w_eff_state != c_st_idle) begin
            if (in_eol && !in_req) begin
                w_sync_err = 1'b1;
            end
            if (in_eof && !(in_req && in_eol)) begin
                w_sync_err = 1'b1;
            end
        end

        case (w_eff_state)
            c_st_idle: begin
                w_state_nxt = c_st_idle;
            end
            c_st_armed, c_st_active: begin
                w_state_nxt = w_eff_state;
                if (in_req) begin
                    w_pix_ok    = 1'b1;
                    w_state_nxt = c_st_active;
                    if (in_eol) begin
                        w_line_close = 1'b1;
                        if (in_eof) begin
                            w_frame_close = 1'b1;
                            w_state_nxt   = c_st_done;
                        end
                    end
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_done;
                if (in_req) begin
                    w_sync_err = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters: base values already reflect a coincident vsync clear
    // ------------------------------------------------------------------------
    assign w_pix_base  = in_vsync ? 12'd0 : r_pix_cntr;
    assign w_pix_inc   = (w_pix_base == c_pix_max) ? c_pix_max : (w_pix_base + 12'd1);
    assign w_line_base = in_vsync ? 11'd0 : r_line_cntr;
    assign w_line_inc  = (w_line_base == c_line_max) ? c_line_max : (w_line_base + 11'd1);

    assign w_new_line_err  = w_line_close  && (w_pix_inc  != c_exp_width);
    assign w_new_frame_err = w_frame_close && (w_line_inc != c_exp_height);

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            r_pix_cntr        <= 12'd0;
            r_line_cntr       <= 11'd0;
            r_frame_done      <= 1'b0;
            r_frame_cnt       <= 16'd0;
            r_line_len        <= 12'd0;
            r_frame_lines     <= 11'd0;
            r_err_line_len    <= 1'b0;
            r_err_frame_lines <= 1'b0;
            r_err_sync        <= 1'b0;
        end else begin
            r_frame_done <= w_frame_close;

            if (w_line_close) begin
                r_pix_cntr  <= 12'd0;
                r_line_cntr <= w_line_inc;
                r_line_len  <= w_pix_inc;
            end else begin
                r_pix_cntr  <= w_pix_ok ? w_pix_inc : w_pix_base;
                r_line_cntr <= w_line_base;
            end

            if (w_frame_close) begin
                r_frame_lines <= w_line_inc;
                r_frame_cnt   <= r_frame_cnt + 16'd1;
            end

            // A fresh error in the clearing cycle keeps its flag set
            r_err_line_len    <= (r_err_line_len    && !clr_err) || w_new_line_err;
            r_err_frame_lines <= (r_err_frame_lines && !clr_err) || w_new_frame_err;
            r_err_sync        <= (r_err_sync        && !clr_err) || w_sync_err;
        end
    end

    // ------------------------------------------------------------------------
    // Optional per-frame CRC-32
    // ------------------------------------------------------------------------
`ifdef VI_CHECK_CRC_EN
    localparam logic [31:0] c_crc_poly = 32'hEDB88320;
    localparam logic [31:0] c_crc_init = 32'hFFFFFFFF;

    logic [31:0] r_crc;
    logic [31:0] w_crc_base;
    logic [31:0] w_crc_nxt;
    logic [31:0] r_frame_crc;

    // Reflected CRC consumes LSB first, so the three bytes in [7:0],[15:8],
    // [23:16] order are simply pixel bits 0..23.
    function automatic logic [31:0] f_crc24(input logic [31:0] crc_in,
                                            input logic [23:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 24; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        end
        return c;
    endfunction

    assign w_crc_base = in_vsync ? c_crc_init : r_crc;
    assign w_crc_nxt  = f_crc24(w_crc_base, in_pixel);

    always_ff @(posedge vo_clk) begin
        if (vo_reset) begin
            r_crc       <= c_crc_init;
            r_frame_crc <= 32'd0;
        end else begin
            r_crc <= w_pix_ok ? w_crc_nxt : w_crc_base;
            if (w_frame_close) begin
                r_frame_crc <= w_crc_nxt ^ c_crc_init;
            end
        end
    end

    assign frame_crc = r_frame_crc;
`else
    // Pixel data is only consumed by the CRC
    logic w_unused_pixel;
    assign w_unused_pixel = ^in_pixel;
    assign frame_crc      = 32'd0;
`endif

    assign frame_done      = r_frame_done;
    assign frame_cnt       = r_frame_cnt;
    assign line_len        = r_line_len;
    assign frame_lines     = r_frame_lines;
    assign err_line_len    = r_err_line_len;
    assign err_frame_lines = r_err_frame_lines;
    assign err_sync        = r_err_sync;

endmodule
`default_nettype wire

// File: tb/tb_vi_stream_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_vi_stream_checker
// Purpose  : Self-checking bench for vi_stream_checker with EXP_WIDTH=8,
//            EXP_HEIGHT=4. Frames are described as a list of line lengths;
//            expected geometry, sticky flags, frame count and CRC-32 are
//            derived from that description.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vi_stream_checker;

    localparam int EXP_WIDTH  = 8;
    localparam int EXP_HEIGHT = 4;

    logic        vo_clk = 1'b0;
    logic        vo_reset;
    logic        in_vsync;
    logic        in_req;
    logic        in_eol;
    logic        in_eof;
    logic [23:0] in_pixel;
    logic        clr_err;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [11:0] line_len;
    logic [10:0] frame_lines;
    logic        err_line_len;
    logic        err_frame_lines;
    logic        err_sync;
    logic [31:0] frame_crc;

    vi_stream_checker #(
        .EXP_WIDTH  (EXP_WIDTH),
        .EXP_HEIGHT (EXP_HEIGHT)
    ) u_dut (
        .vo_clk          (vo_clk),
        .vo_reset        (vo_reset),
        .in_vsync        (in_vsync),
        .in_req          (in_req),
        .in_eol          (in_eol),
        .in_eof          (in_eof),
        .in_pixel        (in_pixel),
        .clr_err         (clr_err),
        .frame_done      (frame_done),
        .frame_cnt       (frame_cnt),
        .line_len        (line_len),
        .frame_lines     (frame_lines),
        .err_line_len    (err_line_len),
        .err_frame_lines (err_frame_lines),
        .err_sync        (err_sync),
        .frame_crc       (frame_crc)
    );

    always #5 vo_clk = ~vo_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] exp_frame_cnt;
    logic [11:0] exp_line_len;
    logic [10:0] exp_frame_lines;
    logic        exp_err_line;
    logic        exp_err_frame;
    logic        exp_err_sync;
    logic [31:0] exp_crc;

    int          frame_len [4096];
    byte unsigned fbytes [$];

    function automatic logic [31:0] ref_crc();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fbytes[i]) begin
            c = c ^ {24'd0, fbytes[i]};
            for (int b = 0; b < 8; b++) begin
                if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
                else      c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic model_reset();
        exp_frame_cnt   = 16'd0;
        exp_line_len    = 12'd0;
        exp_frame_lines = 11'd0;
        exp_err_line    = 1'b0;
        exp_err_frame   = 1'b0;
        exp_err_sync    = 1'b0;
        exp_crc         = 32'd0;
    endtask

    // One clock: apply inputs, let the edge happen, sample 1 ns later
    task automatic drive(input bit vs, input bit rq, input bit eo, input bit ef,
                         input logic [23:0] px, input bit clr);
        in_vsync = vs;
        in_req   = rq;
        in_eol   = eo;
        in_eof   = ef;
        in_pixel = px;
        clr_err  = clr;
        @(posedge vo_clk);
        #1;
        in_vsync = 1'b0;
        in_req   = 1'b0;
        in_eol   = 1'b0;
        in_eof   = 1'b0;
        clr_err  = 1'b0;
    endtask

    // vs_mode: 0 = no vsync, 1 = separate vsync cycle, 2 = vsync with first pixel
    task automatic send_frame(input int nlines, input int vs_mode,
                              input bit rnd_data, input int gap_max);
        int seq;
        bit first;
        logic [23:0] px;
        seq = 0;
        fbytes.delete();
        if (vs_mode == 1) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL vsync_frame_done: got %0b expected 0", frame_done);
            end
        end
        first = (vs_mode == 2);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < frame_len[l]; p++) begin
                bit eol;
                bit eof;
                if (!first) begin
                    repeat ($urandom_range(gap_max, 0)) begin
                        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
                        checks++;
                        if (frame_done !== 1'b0) begin
                            errors++;
                            $display("FAIL gap_frame_done: got %0b expected 0", frame_done);
                        end
                    end
                end
                px  = rnd_data ? 24'($urandom) : 24'(seq);
                seq++;
                eol = (p == frame_len[l] - 1);
                eof = eol && (l == nlines - 1);
                drive(first, 1'b1, eol, eof, px, 1'b0);
                first = 1'b0;
                fbytes.push_back(px[7:0]);
                fbytes.push_back(px[15:8]);
                fbytes.push_back(px[23:16]);
                if (eol) begin
                    exp_line_len = (frame_len[l] > 4095) ? 12'd4095 : 12'(frame_len[l]);
                    if (frame_len[l] != EXP_WIDTH) exp_err_line = 1'b1;
                    checks++;
                    if (line_len !== exp_line_len) begin
                        errors++;
                        $display("FAIL line_len: got %0d expected %0d (line %0d)", line_len, exp_line_len, l);
                    end
                    checks++;
                    if (err_line_len !== exp_err_line) begin
                        errors++;
                        $display("FAIL err_line_len: got %0b expected %0b (line %0d)", err_line_len, exp_err_line, l);
                    end
                end
                if (eof) begin
                    exp_frame_lines = (nlines > 2047) ? 11'd2047 : 11'(nlines);
                    if (nlines != EXP_HEIGHT) exp_err_frame = 1'b1;
                    exp_frame_cnt = exp_frame_cnt + 16'd1;
`ifdef VI_CHECK_CRC_EN
                    exp_crc = ref_crc();
`else
                    exp_crc = 32'd0;
`endif
                    checks++;
                    if (frame_done !== 1'b1) begin
                        errors++;
                        $display("FAIL eof_frame_done: got %0b expected 1", frame_done);
                    end
                    checks++;
                    if (frame_cnt !== exp_frame_cnt) begin
                        errors++;
                        $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, exp_frame_cnt);
                    end
                    checks++;
                    if (frame_lines !== exp_frame_lines) begin
                        errors++;
                        $display("FAIL frame_lines: got %0d expected %0d", frame_lines, exp_frame_lines);
                    end
                    checks++;
                    if (err_frame_lines !== exp_err_frame) begin
                        errors++;
                        $display("FAIL err_frame_lines: got %0b expected %0b", err_frame_lines, exp_err_frame);
                    end
                    checks++;
                    if (err_sync !== exp_err_sync) begin
                        errors++;
                        $display("FAIL err_sync_eof: got %0b expected %0b", err_sync, exp_err_sync);
                    end
                    checks++;
                    if (frame_crc !== exp_crc) begin
                        errors++;
                        $display("FAIL frame_crc: got %08h expected %08h", frame_crc, exp_crc);
                    end
                end else begin
                    checks++;
                    if (frame_done !== 1'b0) begin
                        errors++;
                        $display("FAIL pix_frame_done: got %0b expected 0", frame_done);
                    end
                end
            end
        end
        // frame_done must drop after one cycle
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_width: got %0b expected 0", frame_done);
        end
    endtask

    task automatic set_lines(input int n, input int len);
        for (int i = 0; i < n; i++) frame_len[i] = len;
    endtask

    task automatic test_reset();
        vo_reset = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
        model_reset();
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %0b expected 0", frame_done); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++;
        if (line_len !== 12'd0) begin errors++; $display("FAIL rst_line_len: got %0d expected 0", line_len); end
        checks++;
        if (frame_lines !== 11'd0) begin errors++; $display("FAIL rst_frame_lines: got %0d expected 0", frame_lines); end
        checks++;
        if ({err_line_len, err_frame_lines, err_sync} !== 3'b000) begin
            errors++;
            $display("FAIL rst_err_flags: got %03b expected 000", {err_line_len, err_frame_lines, err_sync});
        end
        checks++;
        if (frame_crc !== 32'd0) begin errors++; $display("FAIL rst_frame_crc: got %08h expected 0", frame_crc); end
        vo_reset = 1'b0;
    endtask

    task automatic test_clean_frames();
        set_lines(EXP_HEIGHT, EXP_WIDTH);
        for (int f = 0; f < 3; f++) send_frame(EXP_HEIGHT, 1, 1'b1, 2);
        checks++;
        if (frame_cnt !== 16'd3) begin errors++; $display("FAIL clean_frame_cnt: got %0d expected 3", frame_cnt); end
        checks++;
        if ({err_line_len, err_frame_lines, err_sync} !== 3'b000) begin
            errors++;
            $display("FAIL clean_err_flags: got %03b expected 000", {err_line_len, err_frame_lines, err_sync});
        end
    endtask

    task automatic test_short_line();
        set_lines(EXP_HEIGHT, EXP_WIDTH);
        frame_len[2] = 7;
        send_frame(EXP_HEIGHT, 1, 1'b1, 1);
        set_lines(EXP_HEIGHT, EXP_WIDTH);
        send_frame(EXP_HEIGHT, 1, 1'b1, 1);
        checks++;
        if (err_line_len !== 1'b1) begin errors++; $display("FAIL short_sticky: got %0b expected 1", err_line_len); end
    endtask

    task automatic test_early_eof();
        set_lines(3, EXP_WIDTH);
        send_frame(3, 1, 1'b1, 0);
    endtask

    task automatic test_clr_err();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1);
        exp_err_line  = 1'b0;
        exp_err_frame = 1'b0;
        exp_err_sync  = 1'b0;
        checks++;
        if ({err_line_len, err_frame_lines, err_sync} !== 3'b000) begin
            errors++;
            $display("FAIL clr_all: got %03b expected 000", {err_line_len, err_frame_lines, err_sync});
        end
    endtask

    task automatic test_vsync_mid_line();
        logic [15:0] cnt_before;
        cnt_before = exp_frame_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
        exp_err_sync = 1'b1;
        checks++;
        if (err_sync !== 1'b1) begin errors++; $display("FAIL vsync_mid_err: got %0b expected 1", err_sync); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL vsync_mid_done: got %0b expected 0", frame_done); end
        checks++;
        if (frame_cnt !== cnt_before) begin errors++; $display("FAIL vsync_mid_cnt: got %0d expected %0d", frame_cnt, cnt_before); end
        // Abandoned frame: following lines are counted from zero without a new vsync
        set_lines(EXP_HEIGHT, EXP_WIDTH);
        send_frame(EXP_HEIGHT, 0, 1'b1, 1);
    endtask

    task automatic test_eol_without_req();
        test_clr_err();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
        exp_err_sync = 1'b1;
        checks++;
        if (err_sync !== 1'b1) begin errors++; $display("FAIL eol_no_req: got %0b expected 1", err_sync); end
    endtask

    task automatic test_clr_with_req_in_done();
        // Make the line/frame flags set so their clearing is visible
        set_lines(2, 5);
        send_frame(2, 1, 1'b1, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom), 1'b1);
        exp_err_line  = 1'b0;
        exp_err_frame = 1'b0;
        exp_err_sync  = 1'b1;
        checks++;
        if ({err_line_len, err_frame_lines, err_sync} !== 3'b001) begin
            errors++;
            $display("FAIL clr_vs_req_done: got %03b expected 001", {err_line_len, err_frame_lines, err_sync});
        end
        test_clr_err();
    endtask

    task automatic test_crc();
        set_lines(EXP_HEIGHT, EXP_WIDTH);
        send_frame(EXP_HEIGHT, 1, 1'b0, 0);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(5, 3);
            for (int l = 0; l < n; l++) frame_len[l] = ($urandom_range(3, 0) == 0) ? $urandom_range(9, 7) : EXP_WIDTH;
            send_frame(n, $urandom_range(2, 1), 1'b1, 2);
        end
    endtask

    task automatic test_saturation();
        frame_len[0] = 4100;
        send_frame(1, 1, 1'b1, 0);
        set_lines(2050, 1);
        send_frame(2050, 2, 1'b1, 0);
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 24'($urandom), 1'b0);
        test_reset();
        // Everything before the next vsync is ignored
        drive(1'b0, 1'b0, 1'b1, 1'b0, 24'd0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL idle_done: got %0b expected 0", frame_done); end
        checks++;
        if (err_sync !== 1'b0) begin errors++; $display("FAIL idle_err_sync: got %0b expected 0", err_sync); end
        checks++;
        if (line_len !== 12'd0) begin errors++; $display("FAIL idle_line_len: got %0d expected 0", line_len); end
        set_lines(EXP_HEIGHT, EXP_WIDTH);
        send_frame(EXP_HEIGHT, 1, 1'b1, 1);
    endtask

    initial begin
        in_vsync = 1'b0;
        in_req   = 1'b0;
        in_eol   = 1'b0;
        in_eof   = 1'b0;
        in_pixel = 24'd0;
        clr_err  = 1'b0;
        vo_reset = 1'b1;
        model_reset();

        test_reset();
        test_clean_frames();
        test_short_line();
        test_early_eof();
        test_clr_err();
        test_vsync_mid_line();
        test_eol_without_req();
        test_clr_with_req_in_done();
        test_crc();
        test_random_frames();
        test_saturation();
        test_reset_mid_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
